delay_line_ctrl: RTL and testbench

Streaming sample-delay controller that drives an external single-clock dual-port RAM (WIDTH x DEPTH, 1-cycle registered read that holds its value while rd_en=0) as a circular buffer. Each accepted input sample is written to the RAM. The output for that sample is the value accepted `delay` samples earlier. Valid/ready handshakes sit on both the input and output streams. The block sits between an upstream sample source and downstream DSP in the delay-line datapath.

---
 rtl/delay_line_ctrl.sv | 136 +++++++++++++
 tb/tb_delay_line_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl
// Streaming sample-delay controller. An external single-clock dual-port RAM
// (WIDTH x DEPTH, registered read that holds while rd_en=0) is used as a
// circular buffer. Each accepted sample is written at wr_ptr. The sample
// accepted `delay_reg` samples earlier is read back in the same cycle, and it
// appears on m_data one cycle after acceptance.
//
// Ports:
//   clk, sreset           clock, synchronous active-high reset
//   delay, delay_load     new delay (0..DEPTH-1, larger values clamp), load pulse
//   s_valid/s_ready/s_data  input stream
//   m_valid/m_ready/m_data  output stream (delayed samples)
//   ram_wr_*              RAM write port (addr, en, data)
//   ram_rd_*              RAM read port (addr, en) and registered read data
//
// Build option:
//   DELAY_LINE_ZERO_FILL_EN  when defined, samples accepted before the buffer
//                            holds delay_reg samples (since reset or a delay
//                            load) are output as zero instead of stale RAM data.
module delay_line_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  sreset,
    input  logic [ADDR_WIDTH-1:0] delay,
    input  logic                  delay_load,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic                  ram_wr_en,
    output logic [WIDTH-1:0]      ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic                  ram_rd_en,
    input  logic [WIDTH-1:0]      ram_rd_data
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    // Delays that do not fit the buffer are limited to the longest one it holds.
    function automatic logic [ADDR_WIDTH-1:0] clamp_delay(input logic [ADDR_WIDTH-1:0] d);
        if ({1'b0, d} >= DEPTH_X)
            return LAST;
        return d;
    endfunction

    // (ptr - dly) mod DEPTH without relying on DEPTH being a power of two.
    function automatic logic [ADDR_WIDTH-1:0] rd_addr_of(input logic [ADDR_WIDTH-1:0] ptr,
                                                        input logic [ADDR_WIDTH-1:0] dly);
        logic [ADDR_WIDTH:0] a;
        if (ptr >= dly)
            a = {1'b0, ptr} - {1'b0, dly};
        else
            a = {1'b0, ptr} + DEPTH_X - {1'b0, dly};
        return a[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
        if (ptr == LAST)
            return '0;
        return ptr + ADDR_WIDTH'(1);
    endfunction

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] delay_reg;
    logic                  acc;
    logic                  vld_p1;
    logic                  byp_sel_p1;
    logic [WIDTH-1:0]      byp_data_p1;

    // Stage 0: handshake and RAM access for the accepted sample
    assign s_ready     = !vld_p1 || m_ready;
    assign acc         = s_valid && s_ready;
    assign ram_wr_en   = acc;
    assign ram_wr_addr = wr_ptr;
    assign ram_wr_data = s_data;
    // No read at delay 0: the sample bypasses the RAM, and this also keeps the
    // read and write addresses distinct whenever both ports are active.
    assign ram_rd_en   = acc && (delay_reg != '0);
    assign ram_rd_addr = rd_addr_of(wr_ptr, delay_reg);

    always_ff @(posedge clk) begin
        if (sreset) begin
            wr_ptr      <= '0;
            delay_reg   <= '0;
            vld_p1      <= 1'b0;
            byp_sel_p1  <= 1'b0;
            byp_data_p1 <= '0;
        end else begin
            vld_p1 <= acc || (vld_p1 && !m_ready);
            // Select registers load only on accept so a stalled output holds.
            if (acc) begin
                wr_ptr      <= next_ptr(wr_ptr);
                byp_sel_p1  <= (delay_reg == '0);
                byp_data_p1 <= s_data;
            end
            // A sample accepted together with a load still used the old delay.
            if (delay_load)
                delay_reg <= clamp_delay(delay);
        end
    end

    // Stage 1: output select
    assign m_valid = vld_p1;

`ifdef DELAY_LINE_ZERO_FILL_EN
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic                  zero_p1;

    always_ff @(posedge clk) begin
        if (sreset) begin
            fill_cnt <= '0;
            zero_p1  <= 1'b0;
        end else begin
            if (acc)
                zero_p1 <= (fill_cnt < delay_reg);
            // The load restarts filling and overrides this cycle's increment.
            if (delay_load)
                fill_cnt <= '0;
            else if (acc && (fill_cnt < delay_reg))
                fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
        end
    end

    assign m_data = byp_sel_p1 ? byp_data_p1 : (zero_p1 ? '0 : ram_rd_data);
`else
    assign m_data = byp_sel_p1 ? byp_data_p1 : ram_rd_data;
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench for delay_line_ctrl with a behavioural RAM and a
// reference model built on a sample queue and a shadow memory.
module tb_delay_line_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             sreset;
    logic [AW-1:0]    delay;
    logic             delay_load;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [AW-1:0]    ram_wr_addr;
    logic             ram_wr_en;
    logic [WIDTH-1:0] ram_wr_data;
    logic [AW-1:0]    ram_rd_addr;
    logic             ram_rd_en;
    logic [WIDTH-1:0] ram_rd_data;
    logic             ram_clr;

    always #5 clk = ~clk;

    delay_line_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .sreset     (sreset),
        .delay      (delay),
        .delay_load (delay_load),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_en  (ram_wr_en),
        .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_en  (ram_rd_en),
        .ram_rd_data(ram_rd_data)
    );

    // External RAM: registered read that holds while rd_en is low.
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 8'(224 + i);
            ram_rd_data <= '0;
        end else begin
            if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
            if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
        end
    end

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mem_m [DEPTH];
    int               ptr_m;
    int               dly_m;
    int               fill_m;
    int               n_cmp = 0;
    int               n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic cyc(input logic sv, input logic [WIDTH-1:0] sd, input logic mr,
                       input logic ld, input logic [AW-1:0] dl, input logic rst);
        logic             acc_e;
        logic             busy;
        logic [WIDTH-1:0] exp_d;
        int               ra;
        @(negedge clk);
        s_valid    = sv;
        s_data     = sd;
        m_ready    = mr;
        delay_load = ld;
        delay      = dl;
        sreset     = rst;
        ram_clr    = 1'b0;
        #1;
        busy  = (exp_q.size() != 0);
        acc_e = sv && (!busy || mr);
        ra    = (ptr_m - dly_m + DEPTH) % DEPTH;
        chk("m_valid", 32'(m_valid), 32'(busy));
        chk("s_ready", 32'(s_ready), 32'(!busy || mr));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(acc_e));
        chk("ram_wr_addr", 32'(ram_wr_addr), 32'(ptr_m));
        chk("ram_rd_addr", 32'(ram_rd_addr), 32'(ra));
        chk("ram_rd_en", 32'(ram_rd_en), 32'(acc_e && (dly_m != 0)));
        if (acc_e) chk("ram_wr_data", 32'(ram_wr_data), 32'(sd));
        if (busy) chk("m_data", 32'(m_data), 32'(exp_q[0]));

        if (rst) begin
            exp_q.delete();
            ptr_m  = 0;
            dly_m  = 0;
            fill_m = 0;
        end else begin
            if (busy && mr) void'(exp_q.pop_front());
            if (acc_e) begin
                if (dly_m == 0)
                    exp_d = sd;
                else begin
`ifdef DELAY_LINE_ZERO_FILL_EN
                    exp_d = (fill_m < dly_m) ? '0 : mem_m[ra];
`else
                    exp_d = mem_m[ra];
`endif
                end
                exp_q.push_back(exp_d);
                mem_m[ptr_m] = sd;
                ptr_m = (ptr_m + 1) % DEPTH;
                fill_m++;
            end
            if (ld) begin
                dly_m  = (int'(dl) > DEPTH - 1) ? DEPTH - 1 : int'(dl);
                fill_m = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic load(input logic [AW-1:0] d);
        cyc(1'b0, '0, 1'b1, 1'b1, d, 1'b0);
    endtask

    initial begin
        sreset     = 1'b1;
        ram_clr    = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b1;
        delay_load = 1'b0;
        delay      = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'(224 + i);
        ptr_m  = 0;
        dly_m  = 0;
        fill_m = 0;

        // Reset state, then bypass at delay 0
        cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        idle(1);
        load(3'd0);
        for (int v = 1; v <= 3; v++) cyc(1'b1, 8'(v), 1'b1, 1'b0, '0, 1'b0);
        idle(2);

        // Basic delay of 3
        load(3'd3);
        for (int v = 10; v <= 17; v++) cyc(1'b1, 8'(v), 1'b1, 1'b0, '0, 1'b0);
        idle(2);

        // Longest delay, pointers wrap
        load(3'd7);
        for (int v = 1; v <= 20; v++) cyc(1'b1, 8'(v), 1'b1, 1'b0, '0, 1'b0);
        idle(2);

        // Backpressure with samples waiting upstream
        load(3'd2);
        cyc(1'b1, 8'd5, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'd6, 1'b0, 1'b0, '0, 1'b0);
        for (int v = 6; v <= 9; v++) cyc(1'b1, 8'(v), 1'b1, 1'b0, '0, 1'b0);
        idle(2);

        // Delay change coinciding with an accept
        load(3'd2);
        for (int v = 40; v <= 45; v++) cyc(1'b1, 8'(v), 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 8'd50, 1'b1, 1'b1, 3'd4, 1'b0);
        for (int v = 51; v <= 60; v++) cyc(1'b1, 8'(v), 1'b1, 1'b0, '0, 1'b0);
        idle(2);

        // Reset while an output is stalled
        load(3'd1);
        cyc(1'b1, 8'd70, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 8'd71, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 8'd72, 1'b1, 1'b0, '0, 1'b0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic rst_r;
            rst_r = ($urandom_range(0, 199) == 0);
            cyc(rst_r ? 1'b0 : ($urandom_range(0, 3) != 0),
                8'($urandom),
                ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 39) == 0),
                AW'($urandom_range(0, DEPTH - 1)),
                rst_r);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
